// File: rtl/regfile_scan.sv
// Register file with two async read ports, one sync write port,
// and a valid/ready debug scan engine that streams every register.
module regfile_scan #(
  parameter int XLEN       = 32,
  parameter int NREG       = 32,
  parameter int AW         = 5,
  parameter int RESET_MODE = 1,
  parameter int X0_ZERO    = 1,
  parameter int BYPASS     = 1
) (
  input  logic            CLK,
  input  logic            RST_RF,
  input  logic            RegWrite,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            DBG_START,
  input  logic            DBG_READY,
  output logic            DBG_VALID,
  output logic [AW-1:0]   DBG_IDX,
  output logic [XLEN-1:0] DBG_DATA,
  output logic            DBG_BUSY,
  output logic            DBG_DONE
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(NREG - 1);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];

  state_t          state_q, state_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [XLEN-1:0] data_q, data_d;

  logic            x0_drop;
  logic            we_eff;
  logic [AW-1:0]   sc_addr;
  logic [XLEN-1:0] sc_data;

  assign x0_drop = (X0_ZERO != 0) && (A3 == '0);
  assign we_eff  = RegWrite && !x0_drop;

  always_comb begin
    regs_d = regs_q;
    if (we_eff) regs_d[A3] = WD3;
  end

  always_comb begin
    RD1 = regs_q[A1];
    if ((X0_ZERO != 0) && (A1 == '0)) RD1 = '0;
    if ((BYPASS != 0) && we_eff && (A3 == A1)) RD1 = WD3;
  end

  always_comb begin
    RD2 = regs_q[A2];
    if ((X0_ZERO != 0) && (A2 == '0)) RD2 = '0;
    if ((BYPASS != 0) && we_eff && (A3 == A2)) RD2 = WD3;
  end

  // Third read port: next beat is fetched from pre-write contents
  always_comb begin
    sc_addr = '0;
    if (state_q == S_SEND) sc_addr = idx_q + AW'(1);
    sc_data = regs_q[sc_addr];
    if ((X0_ZERO != 0) && (sc_addr == '0)) sc_data = '0;
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    DBG_VALID = 1'b0;
    DBG_BUSY  = 1'b0;
    DBG_DONE  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (DBG_START) begin
          state_d = S_SEND;
          idx_d   = '0;
          data_d  = sc_data;
        end
      end
      S_SEND: begin
        DBG_VALID = 1'b1;
        DBG_BUSY  = 1'b1;
        if (DBG_READY) begin
          if (idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d  = sc_addr;
            data_d = sc_data;
          end
        end
      end
      S_DONE: begin
        DBG_BUSY = 1'b1;
        DBG_DONE = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign DBG_IDX  = idx_q;
  assign DBG_DATA = data_q;

  always_ff @(posedge CLK or posedge RST_RF) begin
    if (RST_RF) begin
      for (int i = 0; i < NREG; i++) begin
        if ((RESET_MODE != 0) && !((X0_ZERO != 0) && (i == 0)))
          regs_q[i] <= XLEN'(i);
        else
          regs_q[i] <= '0;
      end
      state_q <= S_IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      regs_q  <= regs_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: doc/regfile_scan.md
Name: regfile_scan

Overview:
Parametrised register file for the RISC-V core, with a built-in debug scan engine that streams every register out to the VGA text overlay. It offers two combinational read ports and one synchronous write port, a hardwired x0 and optional write-to-read bypass. The scan engine uses a valid/ready handshake, so the VGA side can throttle the readout without stalling the core.

Parameters:
XLEN, 32, register width in bits
NREG, 32, number of registers (power of 2, 2..64)
AW, 5, address width, equal to log2(NREG)
RESET_MODE, 1, 0 resets every register to 0; 1 resets register i to i, truncated to XLEN
X0_ZERO, 1, 1 means register 0 always reads 0 and ignores writes
BYPASS, 1, 1 means a same-cycle write is forwarded to RD1/RD2

Ports:
CLK  input  1  clock, rising edge
RST_RF  input  1  reset, asynchronous, active-high
RegWrite  input  1  write enable
A1  input  AW  read address, port 1
A2  input  AW  read address, port 2
A3  input  AW  write address
WD3  input  XLEN  write data
RD1  output  XLEN  read data, port 1 (combinational)
RD2  output  XLEN  read data, port 2 (combinational)
DBG_START  input  1  single-cycle request to begin a full scan
DBG_READY  input  1  consumer accepts the current beat
DBG_VALID  output  1  DBG_IDX/DBG_DATA are valid
DBG_IDX  output  AW  register index of the current beat
DBG_DATA  output  XLEN  register contents of the current beat
DBG_BUSY  output  1  scan in progress
DBG_DONE  output  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (RST_RF=1, asynchronous):
  - Registers load their RESET_MODE pattern; register 0 is 0 when X0_ZERO=1.
  - The scan FSM goes to IDLE.
  - DBG_VALID, DBG_BUSY and DBG_DONE are 0; DBG_IDX and DBG_DATA are 0.
- Write: on the rising edge of CLK, REG[A3] <= WD3 when RegWrite=1.
  - Writes to A3=0 are dropped when X0_ZERO=1.
  - RegWrite=0 leaves every register unchanged; no X is ever written.
- Read: RD1 = REG[A1] and RD2 = REG[A2], combinational, zero-cycle latency.
  - Register 0 reads as 0 when X0_ZERO=1.
  - With BYPASS=1: if RegWrite=1, A3==An and the write is not dropped, RDn = WD3.
  - With BYPASS=0: RDn shows the new value in the cycle after the write edge.
- Scan FSM, states IDLE, SEND, DONE:
  - IDLE: DBG_BUSY=0, DBG_VALID=0. DBG_START=1 at an edge moves to SEND and loads DBG_IDX=0 and DBG_DATA=REG[0] as sampled at that edge, i.e. the pre-write value. DBG_VALID=1 from the next cycle, so latency is 1 cycle.
  - SEND: DBG_BUSY=1, DBG_VALID=1. DBG_IDX and DBG_DATA are registered and held stable while DBG_READY=0, even if the core writes that register meanwhile.
    - Accept (VALID & READY at an edge) with IDX < NREG-1: IDX <= IDX+1 and DATA <= REG[IDX+1], sampled pre-write at that edge. There is no bubble, so one beat per cycle while READY=1.
    - Accept with IDX == NREG-1: go to DONE and drop DBG_VALID.
  - DONE: DBG_DONE=1 and DBG_BUSY=1 for exactly one cycle, then IDLE. A full scan with READY held high takes NREG+1 cycles from the START edge to the DONE pulse.
- DBG_START is ignored in SEND and DONE; a new scan needs a START while in IDLE.
- The register 0 beat reports 0 when X0_ZERO=1.
- Scan reads use a dedicated third read port and never disturb RD1/RD2 or block writes.
- Reset mid-scan: the FSM aborts to IDLE immediately with VALID=0 and no DONE pulse; registers take their reset pattern.

Test Plan:
- Reset, RESET_MODE=1: after RST_RF pulse, read A1=7, A2=31 -> RD1=7, RD2=31; A1=0 -> RD1=0; all DBG_* = 0.
- Write then read, BYPASS=1: RegWrite=1, A3=5, WD3=0xDEADBEEF, A1=5 in the same cycle -> RD1=0xDEADBEEF that cycle; with RegWrite=0 the next cycle, RD1 is still 0xDEADBEEF.
- x0 protection and RegWrite=0: write 0x1234 to A3=0 -> RD1(A1=0)=0; RegWrite=0 with A3=9, WD3=0xFFFF -> REG[9] stays 9.
- Full-rate scan after reset: START pulse, READY=1 -> VALID from the next cycle; beats IDX=0..31 with DATA=0..31 on consecutive cycles; DONE pulses 1 cycle after the IDX=31 beat, 33 cycles after the START edge; then BUSY=0.
- Backpressure and concurrent write: READY=0 while IDX=3 shows DATA=3; the core writes REG[3]=0xAAAA during the stall -> DATA stays 3 until accepted. REG[4] is written to 0xBBBB before the IDX=3 accept edge -> the next beat shows IDX=4, DATA=0xBBBB.
- Reset mid-scan and ignored START: a START during SEND does not restart the index; assert RST_RF at IDX=10 -> VALID=0 and BUSY=0 immediately, no DONE pulse; a later START scans again from IDX=0.
